// File: rtl/uart_regs_pkg.sv
// Shared constants and payload types for the UART port-mapped register block.
package uart_regs_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DIV_W     = 16;
    localparam int unsigned IRQ_WIDTH = 7;

    // Register offsets relative to BASE_ADDRESS
    localparam logic [DATA_W-1:0] OFF_DATA     = 8'd0;
    localparam logic [DATA_W-1:0] OFF_CONTROL  = 8'd1;
    localparam logic [DATA_W-1:0] OFF_STATUS   = 8'd2;
    localparam logic [DATA_W-1:0] OFF_IRQ_MASK = 8'd3;
    localparam logic [DATA_W-1:0] OFF_IRQ_PEND = 8'd4;
    localparam logic [DATA_W-1:0] OFF_DIV_LO   = 8'd5;
    localparam logic [DATA_W-1:0] OFF_DIV_HI   = 8'd6;

    // Interrupt source bit positions
    localparam int unsigned IRQ_RX_DATA     = 0;
    localparam int unsigned IRQ_RX_HALF     = 1;
    localparam int unsigned IRQ_RX_FULL     = 2;
    localparam int unsigned IRQ_TX_EMPTY    = 3;
    localparam int unsigned IRQ_TX_HALF     = 4;
    localparam int unsigned IRQ_TX_OVERRUN  = 5;
    localparam int unsigned IRQ_RX_UNDERRUN = 6;

    // Control register bit positions
    localparam int unsigned CTL_ENABLE = 0;
    localparam int unsigned CTL_IRQ_EN = 1;
    localparam int unsigned CTL_TX_RST = 2;
    localparam int unsigned CTL_RX_RST = 3;

    // FIFO-reset bits are pulses only and never stored
    localparam logic [DATA_W-1:0] CTL_STORE_MASK = 8'hF3;

    // FIFO flag bundle, laid out exactly as the status register low bits
    typedef struct packed {
        logic tx_full;
        logic tx_half_full;
        logic tx_data_present;
        logic rx_full;
        logic rx_half_full;
        logic rx_data_present;
    } fifo_flags_t;

endpackage

// File: rtl/uart_irq_ctrl.sv
// Edge-detected sticky interrupt sources with mask, W1C clear and ack blocking.
module uart_irq_ctrl
    import uart_regs_pkg::*;
#(
    parameter logic [IRQ_WIDTH-1:0] IRQ_MASK_RESET = 7'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_data_present,
    input  logic                 rx_half_full,
    input  logic                 rx_full,
    input  logic                 tx_data_present,
    input  logic                 tx_half_full,
    input  logic                 tx_overrun,
    input  logic                 rx_underrun,
    input  logic                 mask_wr,
    input  logic                 pend_clr,
    input  logic [IRQ_WIDTH-1:0] wdata,
    input  logic                 irq_enable,
    input  logic                 interrupt_ack,
    output logic [IRQ_WIDTH-1:0] mask,
    output logic [IRQ_WIDTH-1:0] pending,
    output logic                 interrupt
);

    logic                 rx_dp_q, rx_hf_q, rx_full_q, tx_dp_q, tx_hf_q;
    logic                 ack_block;
    logic                 ack_block_nxt;
    logic [IRQ_WIDTH-1:0] set_vec;
    logic [IRQ_WIDTH-1:0] clr_vec;
    logic [IRQ_WIDTH-1:0] masked;

    // Source events: rising RX flags, falling TX flags, plus the bus error strobes
    always_comb begin
        set_vec                  = '0;
        set_vec[IRQ_RX_DATA]     = rx_data_present & ~rx_dp_q;
        set_vec[IRQ_RX_HALF]     = rx_half_full & ~rx_hf_q;
        set_vec[IRQ_RX_FULL]     = rx_full & ~rx_full_q;
        set_vec[IRQ_TX_EMPTY]    = ~tx_data_present & tx_dp_q;
        set_vec[IRQ_TX_HALF]     = ~tx_half_full & tx_hf_q;
        set_vec[IRQ_TX_OVERRUN]  = tx_overrun;
        set_vec[IRQ_RX_UNDERRUN] = rx_underrun;
    end

    // W1C vector and ack-block next state; ack blocks until masked pending drains
    always_comb begin
        clr_vec       = pend_clr ? wdata : '0;
        masked        = pending & mask;
        ack_block_nxt = ack_block;
        if (interrupt_ack) begin
            ack_block_nxt = 1'b1;
        end else if (masked == '0) begin
            ack_block_nxt = 1'b0;
        end
    end

    // Edge-detect history, sticky pending (set beats clear), mask and interrupt flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_dp_q   <= 1'b0;
            rx_hf_q   <= 1'b0;
            rx_full_q <= 1'b0;
            tx_dp_q   <= 1'b0;
            tx_hf_q   <= 1'b0;
            pending   <= '0;
            mask      <= IRQ_MASK_RESET;
            ack_block <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            rx_dp_q   <= rx_data_present;
            rx_hf_q   <= rx_half_full;
            rx_full_q <= rx_full;
            tx_dp_q   <= tx_data_present;
            tx_hf_q   <= tx_half_full;
            pending   <= (pending & ~clr_vec) | set_vec;
            if (mask_wr) begin
                mask <= wdata;
            end
            ack_block <= ack_block_nxt;
            interrupt <= irq_enable & (|masked) & ~ack_block_nxt;
        end
    end

endmodule

// File: rtl/uart_regs_irq.sv
// PicoBlaze port-mapped UART control/status/interrupt/divider register block.
module uart_regs_irq
    import uart_regs_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDRESS   = 8'h00,
    parameter logic [15:0] DIVIDE_RESET   = 16'h0000,
    parameter logic [7:0]  CONTROL_RESET  = 8'h00,
    parameter logic [6:0]  IRQ_MASK_RESET = 7'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  port_id,
    input  logic [7:0]  data_in,
    input  logic        read_strobe,
    input  logic        write_strobe,
    output logic [7:0]  data_out,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic        buffer_write,
    output logic [7:0]  uart_data_write,
    output logic        buffer_read,
    input  logic [7:0]  uart_data_read,
    input  logic        rx_data_present,
    input  logic        rx_half_full,
    input  logic        rx_full,
    input  logic        tx_data_present,
    input  logic        tx_half_full,
    input  logic        tx_full,
    output logic        enable,
    output logic        tx_fifo_reset,
    output logic        rx_fifo_reset,
    output logic [15:0] uart_clock_divide
);

    logic [DATA_W-1:0]    offset;
    logic [DATA_W-1:0]    rd_mux;
    logic [DATA_W-1:0]    control;
    logic [DATA_W-1:0]    shadow;
    logic [IRQ_WIDTH-1:0] irq_mask;
    logic [IRQ_WIDTH-1:0] irq_pending;
    fifo_flags_t          status;
    logic wr_data, wr_ctl, wr_mask, wr_pend, wr_div_lo, wr_div_hi, rd_data;

    assign offset = port_id - BASE_ADDRESS;
    assign enable = control[CTL_ENABLE];

    // Bus strobe decode
    always_comb begin
        wr_data   = write_strobe && (offset == OFF_DATA);
        wr_ctl    = write_strobe && (offset == OFF_CONTROL);
        wr_mask   = write_strobe && (offset == OFF_IRQ_MASK);
        wr_pend   = write_strobe && (offset == OFF_IRQ_PEND);
        wr_div_lo = write_strobe && (offset == OFF_DIV_LO);
        wr_div_hi = write_strobe && (offset == OFF_DIV_HI);
        rd_data   = read_strobe && (offset == OFF_DATA);
    end

    // Status snapshot and read-data mux; unmapped offsets read zero
    always_comb begin
        status.tx_full         = tx_full;
        status.tx_half_full    = tx_half_full;
        status.tx_data_present = tx_data_present;
        status.rx_full         = rx_full;
        status.rx_half_full    = rx_half_full;
        status.rx_data_present = rx_data_present;
        rd_mux = '0;
        case (offset)
            OFF_DATA:     rd_mux = uart_data_read;
            OFF_CONTROL:  rd_mux = control;
            OFF_STATUS:   rd_mux = {2'b00, status};
            OFF_IRQ_MASK: rd_mux = {1'b0, irq_mask};
            OFF_IRQ_PEND: rd_mux = {1'b0, irq_pending};
            OFF_DIV_LO:   rd_mux = uart_clock_divide[7:0];
            OFF_DIV_HI:   rd_mux = uart_clock_divide[15:8];
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, FIFO strobes, control, and shadowed divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out          <= '0;
            buffer_write      <= 1'b0;
            uart_data_write   <= '0;
            buffer_read       <= 1'b0;
            tx_fifo_reset     <= 1'b0;
            rx_fifo_reset     <= 1'b0;
            control           <= CONTROL_RESET & CTL_STORE_MASK;
            shadow            <= '0;
            uart_clock_divide <= DIVIDE_RESET;
        end else begin
            data_out      <= rd_mux;
            buffer_write  <= wr_data & ~tx_full;
            buffer_read   <= rd_data & rx_data_present;
            tx_fifo_reset <= wr_ctl & data_in[CTL_TX_RST];
            rx_fifo_reset <= wr_ctl & data_in[CTL_RX_RST];
            if (wr_data && !tx_full) begin
                uart_data_write <= data_in;
            end
            if (wr_ctl) begin
                control <= data_in & CTL_STORE_MASK;
            end
            if (wr_div_lo) begin
                shadow <= data_in;
            end
            if (wr_div_hi) begin
                uart_clock_divide <= {data_in, shadow};
            end
        end
    end

    uart_irq_ctrl #(
        .IRQ_MASK_RESET (IRQ_MASK_RESET)
    ) u_irq (
        .clk             (clk),
        .reset           (reset),
        .rx_data_present (rx_data_present),
        .rx_half_full    (rx_half_full),
        .rx_full         (rx_full),
        .tx_data_present (tx_data_present),
        .tx_half_full    (tx_half_full),
        .tx_overrun      (wr_data & tx_full),
        .rx_underrun     (rd_data & ~rx_data_present),
        .mask_wr         (wr_mask),
        .pend_clr        (wr_pend),
        .wdata           (data_in[IRQ_WIDTH-1:0]),
        .irq_enable      (control[CTL_IRQ_EN]),
        .interrupt_ack   (interrupt_ack),
        .mask            (irq_mask),
        .pending         (irq_pending),
        .interrupt       (interrupt)
    );

endmodule
